hdmi_scope_controller: RTL and testbench
========================================

// Module: hdmi_scope_controller
// PURPOSE
//  Oscilloscope display engine. Generates video timing (hSync/vSync/VDEn) and a 24-bit pixel stream from two
//  external 1-bit frame buffers (bram, 1-cycle sync read) used ping-pong: one is displayed while the other is
//  redrawn with a waveform built from the VAL_RES-bit input samples. Sits between the ADC sample path and the TMDS encoder.
// PARAMETERS
//  ADDR_WIDTH       19  frame-buffer address width, >= clog2(width*height)
//  VAL_RES          12  sample width in bits
//  OFFSCREEN_MAX_X  800 total pixel clocks per line (active + blanking); must exceed width
//  OFFSCREEN_MAX_Y  525 total lines per frame; must exceed height
//  HFP / HS         16 / 96  horizontal front porch / sync width (pixel clocks)
//  VFP / VS         10 / 2   vertical front porch / sync width (lines)
// PORTS
//  pixclk     in  1          sole clock; all logic rising-edge
//  rst        in  1          synchronous, active-high reset
//  val        in  VAL_RES    sample value
//  readValEn  in  1          sample valid; capture val when high
//  width      in  32         active columns (runtime)
//  height     in  32         active rows (runtime)
//  RD0 / RD1  in  1          read data of buffer 0 / 1
//  VDEn       out 1          active-video enable
//  hSync      out 1          horizontal sync, active high
//  vSync      out 1          vertical sync, active high
//  pixel      out 24         RGB888 pixel
//  WE0 / WE1  out 1          write enable of buffer 0 / 1
//  addrB0/1   out ADDR_WIDTH address of buffer 0 / 1 (read addr when front, write addr when back)
//  WD         out 1          write data, shared by both buffers
// BEHAVIOUR
//  - Timing: counterX 0..OFFSCREEN_MAX_X-1, wraps and increments counterY 0..OFFSCREEN_MAX_Y-1, which wraps to 0.
//    active = X<width && Y<height; hs = X in [width+HFP, width+HFP+HS); vs = Y in [height+VFP, height+VFP+VS).
//  - Read: front-buffer address = Y*width+X (0 when inactive). VDEn/hSync/vSync are active/hs/vs registered
//    (1-cycle delay) to align with the BRAM read. pixel = VDEn ? (RD_front ? 24'hFFFFFF : 24'h000000) : 0.
//  - Writer FSM (back buffer): WRITE -> DONE.
//    WRITE: column-major; at row 0 of each column, if readValEn latch val (else keep previous sample),
//    trow = (height-2) - ((val*(height-1)) >> VAL_RES), clamped to 0; then one row per clock:
//    WE_back=1, addr_back=y*width+col, WD=(y==trow). After col=width-1,y=height-1 -> DONE (WE_back=0).
//    DONE: at last cycle of frame (X=MAX_X-1, Y=MAX_Y-1) toggle front select; next cycle -> WRITE at col 0,y 0.
//    If the frame ends while still in WRITE, no swap; swap at the next frame end after DONE.
//  - Front buffer never has WE asserted; swap only in blanking, so no displayed pixel is torn.
//  - Reset (any time): counters 0, front=buffer0, FSM=WRITE col 0 row 0, latched sample 0; all outputs 0 during rst.
//  - Arithmetic: products widened to 32+VAL_RES bits; addresses truncated to ADDR_WIDTH.
// CONFIGURATION
//  HDMI_GRID_EN defined: inside active area, pixel=24'h404040 where (X%16==0 || Y%16==0) and trace bit is 0;
//  trace (RD=1) stays white. Undefined: pure black/white output, no grid logic generated.
// STRUCTURE
//  Package hdmi_scope_pkg: writer state encoding (WRITE, DONE), colour constants (WHITE, BLACK, GRID), GRID_STEP=16.
//  Sub-module hdmi_timing_gen: counterX/counterY, active/hs/vs decode; top holds writer FSM, ping-pong mux, pixel mux.
// TESTING (width=8, height=6, MAX_X=10, MAX_Y=8, HFP=0, HS=2, VFP=0, VS=2; 80-cycle frame)
//  1 rst held 2 cycles -> all outputs 0, addrB0=0, WE0=WE1=0.
//  2 free run -> hSync high at X=8,9 (1 cycle later), vSync high for lines 6,7, VDEn high 48 cycles/frame.
//  3 val=1000, readValEn=1 -> 48 WE1 pulses; WD=1 only at addr 3*8+c, c=0..7; WE0 never high in frame 0.
//  4 val=0/2000/3000/4000 -> trace row 4/2/1/0; val=4095 -> row 0 (clamp).
//  5 after first frame end -> front=buffer1: pixel=FFFFFF at active X=c,Y=3, else 0; writer now drives WE0.
//  6 readValEn=0 after capturing 1000 -> every column keeps row 3; rst mid-WRITE -> restart col 0, front=buffer0.

Source files
------------

// File: rtl/hdmi_scope_pkg.sv
// rtl/hdmi_scope_pkg.sv - shared writer states and colour constants for the scope display engine
package hdmi_scope_pkg;

  typedef enum logic {
    WRITE = 1'b0,
    DONE  = 1'b1
  } wr_state_e;

  localparam logic [23:0] WHITE     = 24'hFFFFFF;
  localparam logic [23:0] BLACK     = 24'h000000;
  localparam logic [23:0] GRID      = 24'h404040;
  localparam int          GRID_STEP = 16;

endpackage

// File: rtl/hdmi_timing_gen.sv
// rtl/hdmi_timing_gen.sv - pixel/line counters with active, hsync and vsync decode
module hdmi_timing_gen #(
  parameter int OFFSCREEN_MAX_X = 800,
  parameter int OFFSCREEN_MAX_Y = 525,
  parameter int HFP             = 16,
  parameter int HS              = 96,
  parameter int VFP             = 10,
  parameter int VS              = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] width_i,
  input  logic [31:0] height_i,
  output logic [31:0] x_o,
  output logic [31:0] y_o,
  output logic        active_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        frame_end_o
);

  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic        line_end;

  assign line_end = (x_q == 32'(OFFSCREEN_MAX_X - 1));

  always_comb begin
    x_d = x_q + 32'd1;
    y_d = y_q;
    if (line_end) begin
      x_d = '0;
      y_d = (y_q == 32'(OFFSCREEN_MAX_Y - 1)) ? '0 : y_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign active_o    = (x_q < width_i) && (y_q < height_i);
  assign hs_o        = (x_q >= width_i + 32'(HFP)) && (x_q < width_i + 32'(HFP + HS));
  assign vs_o        = (y_q >= height_i + 32'(VFP)) && (y_q < height_i + 32'(VFP + VS));
  assign frame_end_o = line_end && (y_q == 32'(OFFSCREEN_MAX_Y - 1));

endmodule

// File: rtl/hdmi_scope_controller.sv
// rtl/hdmi_scope_controller.sv - ping-pong 1-bit frame buffer scope display; HDMI_GRID_EN adds a grey graticule
module hdmi_scope_controller
  import hdmi_scope_pkg::*;
#(
  parameter int ADDR_WIDTH      = 19,
  parameter int VAL_RES         = 12,
  parameter int OFFSCREEN_MAX_X = 800,
  parameter int OFFSCREEN_MAX_Y = 525,
  parameter int HFP             = 16,
  parameter int HS              = 96,
  parameter int VFP             = 10,
  parameter int VS              = 2
) (
  input  logic                  pixclk,
  input  logic                  rst,
  input  logic [VAL_RES-1:0]    val,
  input  logic                  readValEn,
  input  logic [31:0]           width,
  input  logic [31:0]           height,
  input  logic                  RD0,
  input  logic                  RD1,
  output logic                  VDEn,
  output logic                  hSync,
  output logic                  vSync,
  output logic [23:0]           pixel,
  output logic                  WE0,
  output logic                  WE1,
  output logic [ADDR_WIDTH-1:0] addrB0,
  output logic [ADDR_WIDTH-1:0] addrB1,
  output logic                  WD
);

  logic [31:0] cx, cy;
  logic        active, hs, vs, frame_end;

  hdmi_timing_gen #(
    .OFFSCREEN_MAX_X(OFFSCREEN_MAX_X), .OFFSCREEN_MAX_Y(OFFSCREEN_MAX_Y),
    .HFP(HFP), .HS(HS), .VFP(VFP), .VS(VS)
  ) u_timing (
    .clk_i(pixclk), .rst_i(rst), .width_i(width), .height_i(height),
    .x_o(cx), .y_o(cy), .active_o(active), .hs_o(hs), .vs_o(vs), .frame_end_o(frame_end)
  );

  // Row of the trace pixel for one column; values above the scale clamp to the top row.
  function automatic logic [31:0] trace_row(input logic [VAL_RES-1:0] s, input logic [31:0] h);
    logic [32+VAL_RES-1:0] prod;
    logic [31:0]           scaled;
    prod   = (32+VAL_RES)'(h - 32'd1) * (32+VAL_RES)'(s);
    scaled = 32'(prod >> VAL_RES);
    if (({1'b0, scaled} + 33'd2) > {1'b0, h}) return '0;
    return h - 32'd2 - scaled;
  endfunction

  wr_state_e            state_q, state_d;
  logic [31:0]          col_q, col_d, row_q, row_d, trow_q, trow_d, trow_cur;
  logic [VAL_RES-1:0]   sample_q, sample_d, cur_sample;
  logic                 front_q, front_d;
  logic                 vden_q, hsync_q, vsync_q;
  logic                 writing, we_back, rd_front;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    front_d    = front_q;
    sample_d   = sample_q;
    trow_d     = trow_q;
    cur_sample = sample_q;
    trow_cur   = trow_q;
    writing    = 1'b0;
    case (state_q)
      WRITE: begin
        writing = 1'b1;
        if (row_q == '0) begin
          if (readValEn) cur_sample = val;
          sample_d = cur_sample;
          trow_cur = trace_row(cur_sample, height);
          trow_d   = trow_cur;
        end
        if (row_q == height - 32'd1) begin
          row_d = '0;
          if (col_q == width - 32'd1) begin
            col_d   = '0;
            state_d = DONE;
          end else begin
            col_d = col_q + 32'd1;
          end
        end else begin
          row_d = row_q + 32'd1;
        end
      end
      DONE: begin
        // Swap only on the last blanking cycle so the new front starts clean at pixel 0.
        if (frame_end) begin
          front_d = ~front_q;
          state_d = WRITE;
          col_d   = '0;
          row_d   = '0;
        end
      end
      default: state_d = WRITE;
    endcase
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      state_q  <= WRITE;
      col_q    <= '0;
      row_q    <= '0;
      trow_q   <= '0;
      sample_q <= '0;
      front_q  <= 1'b0;
      vden_q   <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      trow_q   <= trow_d;
      sample_q <= sample_d;
      front_q  <= front_d;
      vden_q   <= active;
      hsync_q  <= hs;
      vsync_q  <= vs;
    end
  end

  assign rd_addr  = active ? ADDR_WIDTH'(cy * width + cx) : '0;
  assign wr_addr  = ADDR_WIDTH'(row_q * width + col_q);
  assign we_back  = writing && !rst;
  assign WE0      = we_back && front_q;
  assign WE1      = we_back && !front_q;
  assign addrB0   = rst ? '0 : (front_q ? wr_addr : rd_addr);
  assign addrB1   = rst ? '0 : (front_q ? rd_addr : wr_addr);
  assign WD       = we_back && (row_q == trow_cur);
  assign VDEn     = vden_q && !rst;
  assign hSync    = hsync_q && !rst;
  assign vSync    = vsync_q && !rst;
  assign rd_front = front_q ? RD1 : RD0;

`ifdef HDMI_GRID_EN
  logic grid_q;

  always_ff @(posedge pixclk) begin
    if (rst) grid_q <= 1'b0;
    else     grid_q <= active && ((cx % 32'(GRID_STEP)) == '0 || (cy % 32'(GRID_STEP)) == '0);
  end

  always_comb begin
    pixel = BLACK;
    if (VDEn) pixel = rd_front ? WHITE : (grid_q ? GRID : BLACK);
  end
`else
  always_comb begin
    pixel = BLACK;
    if (VDEn) pixel = rd_front ? WHITE : BLACK;
  end
`endif

endmodule

// File: tb/tb_hdmi_scope_controller.sv
// tb/tb_hdmi_scope_controller.sv - directed self-checking bench on an 8x6 active / 10x8 total raster
module tb_hdmi_scope_controller;

  localparam int AW = 19;
  localparam int VR = 12;

  logic          pixclk = 1'b0;
  logic          rst;
  logic [VR-1:0] val;
  logic          readValEn;
  logic [31:0]   width, height;
  logic          RD0 = 1'b0, RD1 = 1'b0;
  logic          VDEn, hSync, vSync, WE0, WE1, WD;
  logic [23:0]   pixel;
  logic [AW-1:0] addrB0, addrB1;

  logic [63:0]   mem0 = '0;
  logic [63:0]   mem1 = '0;

  int checks   = 0;
  int failures = 0;
  int wr_trow[4][8];
  int disp_trow[4][8];
  int f1_val[8];

  always #5 pixclk = ~pixclk;

  hdmi_scope_controller #(
    .ADDR_WIDTH(AW), .VAL_RES(VR), .OFFSCREEN_MAX_X(10), .OFFSCREEN_MAX_Y(8),
    .HFP(0), .HS(2), .VFP(0), .VS(2)
  ) dut (
    .pixclk(pixclk), .rst(rst), .val(val), .readValEn(readValEn),
    .width(width), .height(height), .RD0(RD0), .RD1(RD1),
    .VDEn(VDEn), .hSync(hSync), .vSync(vSync), .pixel(pixel),
    .WE0(WE0), .WE1(WE1), .addrB0(addrB0), .addrB1(addrB1), .WD(WD)
  );

  always @(posedge pixclk) begin
    if (WE0) mem0[addrB0[5:0]] <= WD;
    if (WE1) mem1[addrB1[5:0]] <= WD;
    RD0 <= mem0[addrB0[5:0]];
    RD1 <= mem1[addrB1[5:0]];
  end

  task automatic chk(input string tag, input int f, input int k,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s f=%0d k=%0d observed=%0h expected=%0h", tag, f, k, obs, exp);
    end
  endtask

  task automatic check_cycle(input int f, input int k, input bit first, input bit front);
    int x, y, px, py, col, row, rd, wr;
    bit wrt, e_vden, e_hs, e_vs, e_wd;
    logic [31:0] e_pix;
    x = k % 10;  y = k / 10;
    px = ((k + 79) % 80) % 10;
    py = ((k + 79) % 80) / 10;
    e_vden = !first && px < 8 && py < 6;
    e_hs   = !first && px >= 8;
    e_vs   = !first && py >= 6;
    wrt = k < 48;
    col = wrt ? k / 6 : 0;
    row = wrt ? k % 6 : 0;
    rd  = (x < 8 && y < 6) ? y * 8 + x : 0;
    wr  = row * 8 + col;
    e_wd  = wrt && row == wr_trow[f][col];
    e_pix = (e_vden && disp_trow[f][px] == py) ? 32'hFFFFFF : 32'h0;
    chk("vden",   f, k, 32'(VDEn),   32'(e_vden));
    chk("hsync",  f, k, 32'(hSync),  32'(e_hs));
    chk("vsync",  f, k, 32'(vSync),  32'(e_vs));
    chk("we0",    f, k, 32'(WE0),    32'(wrt && front));
    chk("we1",    f, k, 32'(WE1),    32'(wrt && !front));
    chk("wd",     f, k, 32'(WD),     32'(e_wd));
    chk("addrb0", f, k, 32'(addrB0), 32'(front ? wr : rd));
    chk("addrb1", f, k, 32'(addrB1), 32'(front ? rd : wr));
    chk("pixel",  f, k, 32'(pixel),  e_pix);
  endtask

  task automatic check_idle(input int f, input int k);
    chk("rst_vden",   f, k, 32'(VDEn),   32'h0);
    chk("rst_hsync",  f, k, 32'(hSync),  32'h0);
    chk("rst_vsync",  f, k, 32'(vSync),  32'h0);
    chk("rst_pixel",  f, k, 32'(pixel),  32'h0);
    chk("rst_we0",    f, k, 32'(WE0),    32'h0);
    chk("rst_we1",    f, k, 32'(WE1),    32'h0);
    chk("rst_addrb0", f, k, 32'(addrB0), 32'h0);
    chk("rst_addrb1", f, k, 32'(addrB1), 32'h0);
    chk("rst_wd",     f, k, 32'(WD),     32'h0);
  endtask

  initial begin
    f1_val = '{0, 2000, 3000, 4000, 4095, 1000, 0, 0};
    wr_trow[1] = '{4, 2, 1, 0, 0, 3, 3, 3};
    for (int c = 0; c < 8; c++) begin
      wr_trow[0][c]   = 3;
      wr_trow[2][c]   = 3;
      wr_trow[3][c]   = 4;
      disp_trow[0][c] = -1;
      disp_trow[1][c] = 3;
      disp_trow[2][c] = wr_trow[1][c];
      disp_trow[3][c] = wr_trow[1][c];
    end

    rst = 1'b1; val = 12'd1000; readValEn = 1'b1; width = 32'd8; height = 32'd6;
    repeat (2) @(posedge pixclk);
    #1;
    check_idle(-1, 0);
    rst = 1'b0;

    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < ((f == 2) ? 30 : 80); k++) begin
        if (k < 48 && k % 6 == 0) begin
          case (f)
            0:       begin val = 12'd1000; readValEn = 1'b1; end
            1:       begin val = 12'(f1_val[k / 6]); readValEn = (k / 6) < 6; end
            default: begin val = 12'd4095; readValEn = 1'b0; end
          endcase
        end
        #1;
        check_cycle(f, k, k == 0 && (f == 0 || f == 3), f == 1);
        @(posedge pixclk);
        #1;
      end
      if (f == 2) begin
        rst = 1'b1;
        #1;
        check_idle(f, 30);
        @(posedge pixclk);
        #1;
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
